// File: rtl/sdf_r2_bfly_pkg.sv
// Shared definitions for the streaming FFT stages. It holds the SDF stage
// state type, the complex-word pack/unpack helpers, and the scaled add/sub.
// Helpers work on MAX_W-wide containers, so WIDTH up to MAX_W is supported.
package sdf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int MAX_W  = 32;
  localparam int WORD_W = 2 * MAX_W;

  typedef logic signed [MAX_W-1:0] comp_t;
  typedef logic [WORD_W-1:0]       word_t;

  // Real part of a w-bit-per-component word, sign-extended to comp_t.
  function automatic comp_t cplx_re(input word_t word, input int w);
    word_t t;
    t = word << (WORD_W - 2 * w);
    return comp_t'($signed(t) >>> (WORD_W - w));
  endfunction

  // Imaginary part, sign-extended to comp_t.
  function automatic comp_t cplx_im(input word_t word, input int w);
    word_t t;
    t = word << (WORD_W - w);
    return comp_t'($signed(t) >>> (WORD_W - w));
  endfunction

  // Packs the low w bits of each component as {re, im}.
  function automatic word_t cplx_pack(input comp_t re, input comp_t im, input int w);
    word_t mask;
    mask = (word_t'(1) << w) - word_t'(1);
    return ((word_t'(re) & mask) << w) | (word_t'(im) & mask);
  endfunction

  // a+b or a-b at one extra bit of precision, then an optional /2. The caller
  // keeps the low WIDTH bits, which gives wrap-around when scale is off.
  function automatic comp_t addsub_scale(input comp_t a, input comp_t b,
                                         input logic sub, input logic scale);
    logic signed [MAX_W:0] r;
    if (sub) r = $signed({a[MAX_W-1], a}) - $signed({b[MAX_W-1], b});
    else     r = $signed({a[MAX_W-1], a}) + $signed({b[MAX_W-1], b});
    if (scale) r = r >>> 1;
    return comp_t'(r);
  endfunction

endpackage

// File: rtl/sdf_r2_bfly_if.sv
// Interface carrying the SDF stage bus: the input stream, the flush request,
// the delay-line port, and the output stream. All words are {re, im} at 2*WIDTH bits.
// The slave side is the butterfly stage; the master side is its environment.
interface sdf_r2_bfly_if #(parameter int WIDTH = 16);
  logic [2*WIDTH-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [2*WIDTH-1:0] dly_wr_data;
  logic               dly_wr_valid;
  logic [2*WIDTH-1:0] dly_rd_data;
  logic [2*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_diff;
  logic               out_last;

  modport slave (
    input  in_data, in_valid, flush, dly_rd_data,
    output in_ready, dly_wr_data, dly_wr_valid, out_data, out_valid, out_diff, out_last
  );

  modport master (
    output in_data, in_valid, flush, dly_rd_data,
    input  in_ready, dly_wr_data, dly_wr_valid, out_data, out_valid, out_diff, out_last
  );
endinterface

// File: rtl/sdf_r2_bfly_cplx_addsub.sv
// Complex butterfly core: o_sum = scale(a+b), o_diff = scale(a-b) per component.
// Latency: purely combinational.
// Backpressure: none; it is a pure function of its inputs.
// Ports: i_a, i_b are {re, im} operands; o_sum and o_diff are {re, im} results.
module sdf_cplx_addsub
  import sdf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SCALE = 1
) (
  input  logic [2*WIDTH-1:0] i_a,
  input  logic [2*WIDTH-1:0] i_b,
  output logic [2*WIDTH-1:0] o_sum,
  output logic [2*WIDTH-1:0] o_diff
);
  localparam logic C_SCALE = (SCALE != 0);

  comp_t w_a_re, w_a_im, w_b_re, w_b_im;
  comp_t w_s_re, w_s_im, w_t_re, w_t_im;

  assign w_a_re = cplx_re(word_t'(i_a), WIDTH);
  assign w_a_im = cplx_im(word_t'(i_a), WIDTH);
  assign w_b_re = cplx_re(word_t'(i_b), WIDTH);
  assign w_b_im = cplx_im(word_t'(i_b), WIDTH);

  assign w_s_re = addsub_scale(w_a_re, w_b_re, 1'b0, C_SCALE);
  assign w_s_im = addsub_scale(w_a_im, w_b_im, 1'b0, C_SCALE);
  assign w_t_re = addsub_scale(w_a_re, w_b_re, 1'b1, C_SCALE);
  assign w_t_im = addsub_scale(w_a_im, w_b_im, 1'b1, C_SCALE);

  assign o_sum  = (2*WIDTH)'(cplx_pack(w_s_re, w_s_im, WIDTH));
  assign o_diff = (2*WIDTH)'(cplx_pack(w_t_re, w_t_im, WIDTH));
endmodule

// File: rtl/sdf_r2_bfly.sv
// Radix-2 SDF butterfly stage. It emits DEPTH sums per frame, then recirculates the differences.
// Latency: 1 cycle from an accepted sample (or a flush strobe) to its result.
// Backpressure: in_ready drops only while draining stored differences (FLUSH).
// Ports: clk, reset (async, active-high); bus (slave) carries the in/out streams,
// the flush request, and the external delay-line write and read words.
module sdf_r2_bfly
  import sdf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int SCALE = 1
) (
  input  logic          clk,
  input  logic          reset,
  sdf_r2_bfly_if.slave  bus
);
  localparam int             CW         = $clog2(2 * DEPTH);
  localparam logic [CW-1:0]  C_LAST_A   = CW'(DEPTH - 1);
  localparam logic [CW-1:0]  C_LAST_FRM = CW'(2 * DEPTH - 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0] r_out_data;
  logic               r_out_valid, r_out_diff, r_out_last;

  logic               w_accept, w_strobe, w_phase_b, w_primed, w_last_a;
  logic [2*WIDTH-1:0] w_x, w_sum, w_diff;

  // Once a full frame has passed, the delay line holds real differences.
  assign w_primed  = (r_state != EMPTY);
  assign bus.in_ready = (r_state != FLUSH);
  assign w_accept  = bus.in_valid & bus.in_ready;
  assign w_strobe  = w_accept | (r_state == FLUSH);
  assign w_phase_b = r_cnt[CW-1];
  assign w_last_a  = (r_cnt == C_LAST_A);
  // Flush strobes push zeros, so the delay line is clean for the next frame.
  assign w_x       = (r_state == FLUSH) ? '0 : bus.in_data;

  sdf_cplx_addsub #(.WIDTH(WIDTH), .SCALE(SCALE)) u_addsub (
    .i_a    (bus.dly_rd_data),
    .i_b    (w_x),
    .o_sum  (w_sum),
    .o_diff (w_diff)
  );

  assign bus.dly_wr_valid = w_strobe;
  assign bus.dly_wr_data  = w_phase_b ? w_diff : w_x;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_strobe) w_cnt_nxt = r_cnt + CW'(1);
    case (r_state)
      EMPTY: if (w_strobe && r_cnt == C_LAST_FRM) w_state_nxt = RUN;
      // Drain only on a frame boundary with no sample in flight.
      RUN:   if (bus.flush && !bus.in_valid && r_cnt == '0) w_state_nxt = FLUSH;
      FLUSH: if (w_last_a) begin
               w_state_nxt = EMPTY;
               w_cnt_nxt   = '0;
             end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_diff  <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (w_strobe) begin
        r_out_valid <= w_phase_b | w_primed;
        r_out_diff  <= ~w_phase_b;
        r_out_last  <= ~w_phase_b & w_last_a & w_primed;
        r_out_data  <= w_phase_b ? w_sum : bus.dly_rd_data;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_diff  = r_out_diff;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_sdf_r2_bfly.sv
// Bench for sdf_r2_bfly: two instances (SCALE=0 and SCALE=1) share one stimulus stream.
// Each instance gets a behavioural delay line; a frame-level reference model
// predicts every output one cycle after its input.
module tb_sdf_r2_bfly;
  import sdf_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int N     = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_flush = 1'b0;

  sdf_r2_bfly_if #(.WIDTH(WIDTH)) if0 ();
  sdf_r2_bfly_if #(.WIDTH(WIDTH)) if1 ();

  assign if0.in_data = s_data;  assign if0.in_valid = s_valid;  assign if0.flush = s_flush;
  assign if1.in_data = s_data;  assign if1.in_valid = s_valid;  assign if1.flush = s_flush;

  sdf_r2_bfly #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCALE(0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
  sdf_r2_bfly #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCALE(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));

  // Behavioural delay lines: the read word is the one written DEPTH strobes ago.
  logic [31:0] dl0 [DEPTH];
  logic [31:0] dl1 [DEPTH];
  int p0, p1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin dl0[i] <= '0; dl1[i] <= '0; end
      p0 <= 0; p1 <= 0;
    end else begin
      if (if0.dly_wr_valid) begin dl0[p0] <= if0.dly_wr_data; p0 <= (p0 + 1) % DEPTH; end
      if (if1.dly_wr_valid) begin dl1[p1] <= if1.dly_wr_data; p1 <= (p1 + 1) % DEPTH; end
    end
  end
  assign if0.dly_rd_data = dl0[p0];
  assign if1.dly_rd_data = dl1[p1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic logic [15:0] ref_comp(input int a, input int b, input bit sub, input bit scale);
    int r;
    r = sub ? a - b : a + b;
    if (scale) r = r >>> 1;
    return r[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                           input bit sub, input bit scale);
    logic signed [15:0] ar, ai, br, bi;
    ar = a[31:16]; ai = a[15:0]; br = b[31:16]; bi = b[15:0];
    return {ref_comp(int'(ar), int'(br), sub, scale), ref_comp(int'(ai), int'(bi), sub, scale)};
  endfunction

  // Frame-level model: the first half of a frame is buffered; the second half
  // pairs with it. Differences are replayed in the next first half, or by a flush.
  logic [31:0] m_frame [N];
  logic [31:0] m_diff  [2][DEPTH];
  int  m_k = 0, m_fk = 0;
  bit  m_primed = 0, m_flush = 0;
  bit  e_vld = 0, e_diff = 0, e_last = 0;
  logic [31:0] e_dat [2];

  always @(posedge clk) begin
    e_vld  = 0;
    e_last = 0;
    if (rst) begin
      m_k = 0; m_fk = 0; m_primed = 0; m_flush = 0;
      for (int s = 0; s < 2; s++) for (int j = 0; j < DEPTH; j++) m_diff[s][j] = '0;
    end else if (m_flush) begin
      e_vld = 1; e_diff = 1; e_last = (m_fk == DEPTH - 1);
      for (int s = 0; s < 2; s++) e_dat[s] = m_diff[s][m_fk];
      m_fk++;
      if (m_fk == DEPTH) begin m_flush = 0; m_primed = 0; m_k = 0; end
    end else if (s_valid) begin
      if (m_k < DEPTH) begin
        m_frame[m_k] = s_data;
        e_vld = m_primed; e_diff = 1; e_last = m_primed && (m_k == DEPTH - 1);
        for (int s = 0; s < 2; s++) e_dat[s] = m_diff[s][m_k];
      end else begin
        e_vld = 1; e_diff = 0;
        for (int s = 0; s < 2; s++) begin
          e_dat[s] = ref_word(m_frame[m_k - DEPTH], s_data, 1'b0, s[0]);
          m_diff[s][m_k - DEPTH] = ref_word(m_frame[m_k - DEPTH], s_data, 1'b1, s[0]);
        end
      end
      m_k++;
      if (m_k == N) begin m_k = 0; m_primed = 1; end
    end else if (s_flush && m_primed && m_k == 0) begin
      m_flush = 1; m_fk = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_vld0", {31'b0, if0.out_valid}, {31'b0, e_vld});
      chk("m_vld1", {31'b0, if1.out_valid}, {31'b0, e_vld});
      if (e_vld) begin
        chk("m_dat0", if0.out_data, e_dat[0]);
        chk("m_dat1", if1.out_data, e_dat[1]);
        chk("m_diff", {30'b0, if0.out_diff, if1.out_diff}, {30'b0, e_diff, e_diff});
        chk("m_last", {30'b0, if0.out_last, if1.out_last}, {30'b0, e_last, e_last});
      end
      chk("m_rdy", {30'b0, if0.in_ready, if1.in_ready}, {30'b0, !m_flush, !m_flush});
    end
  end

  // Directed table: inputs, then the outputs expected one edge later.
  typedef struct {
    logic [15:0] re; bit vld; bit fl;
    bit ev; logic [15:0] e0; logic [15:0] e1; bit ed; bit el; bit er;
  } vec_t;
  vec_t tbl [32];
  int   nv = 0;

  task automatic add(input logic [15:0] re, input bit vld, input bit fl, input bit ev,
                     input logic [15:0] e0, input logic [15:0] e1,
                     input bit ed, input bit el, input bit er);
    tbl[nv] = '{re, vld, fl, ev, e0, e1, ed, el, er};
    nv++;
  endtask

  task automatic cyc(input logic [31:0] d, input bit v, input bit f);
    s_data = d; s_valid = v; s_flush = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] exp_s [4];

  initial begin
    // Frame 1..8 from reset: sums only.
    add(1,1,0, 0,0,0,0,0,1);            add(2,1,0, 0,0,0,0,0,1);
    add(3,1,0, 0,0,0,0,0,1);            add(4,1,0, 0,0,0,0,0,1);
    add(5,1,0, 1,6,3,0,0,1);            add(6,1,0, 1,8,4,0,0,1);
    add(7,1,0, 1,10,5,0,0,1);           add(8,1,0, 1,12,6,0,0,1);
    // Zero frame: stored differences, then zero sums.
    add(0,1,0, 1,16'hFFFC,16'hFFFE,1,0,1); add(0,1,0, 1,16'hFFFC,16'hFFFE,1,0,1);
    add(0,1,0, 1,16'hFFFC,16'hFFFE,1,0,1); add(0,1,0, 1,16'hFFFC,16'hFFFE,1,1,1);
    add(0,1,0, 1,0,0,0,0,1);            add(0,1,0, 1,0,0,0,0,1);
    add(0,1,0, 1,0,0,0,0,1);            add(0,1,0, 1,0,0,0,0,1);
    // Frame 1..8 again, then a flush at the boundary.
    add(1,1,0, 1,0,0,1,0,1);            add(2,1,0, 1,0,0,1,0,1);
    add(3,1,0, 1,0,0,1,0,1);            add(4,1,0, 1,0,0,1,1,1);
    add(5,1,0, 1,6,3,0,0,1);            add(6,1,0, 1,8,4,0,0,1);
    add(7,1,0, 1,10,5,0,0,1);           add(8,1,0, 1,12,6,0,0,1);
    add(0,0,1, 0,0,0,0,0,0);
    add(0,0,0, 1,16'hFFFC,16'hFFFE,1,0,0); add(0,0,0, 1,16'hFFFC,16'hFFFE,1,0,0);
    add(0,0,0, 1,16'hFFFC,16'hFFFE,1,0,0); add(0,0,0, 1,16'hFFFC,16'hFFFE,1,1,1);
    add(0,0,0, 0,0,0,0,0,1);
    exp_s = '{16'd6, 16'd8, 16'd10, 16'd12};

    repeat (3) @(negedge clk);
    chk("rst_out", {if0.out_data[15:0], 12'b0, if0.out_valid, if0.out_diff, if0.out_last, if0.in_ready},
        32'h0000_0001);
    chk("rst_state", 32'(dut0.r_state), 32'(EMPTY));
    rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      cyc({tbl[i].re, 16'h0}, tbl[i].vld, tbl[i].fl);
      chk($sformatf("tv%0d_vld", i), {30'b0, if0.out_valid, if1.out_valid}, {30'b0, tbl[i].ev, tbl[i].ev});
      chk($sformatf("tv%0d_rdy", i), {31'b0, if0.in_ready}, {31'b0, tbl[i].er});
      if (tbl[i].ev) begin
        chk($sformatf("tv%0d_d0", i), if0.out_data, {tbl[i].e0, 16'h0});
        chk($sformatf("tv%0d_d1", i), if1.out_data, {tbl[i].e1, 16'h0});
        chk($sformatf("tv%0d_fl", i), {30'b0, if0.out_diff, if0.out_last}, {30'b0, tbl[i].ed, tbl[i].el});
      end
    end
    chk("flush_state", 32'(dut0.r_state), 32'(EMPTY));

    // Full-scale input with SCALE=1: the sum stays at +32767, the differences are 0.
    for (int k = 0; k < 2 * N; k++) begin
      cyc(32'h7FFF_0000, 1'b1, 1'b0);
      if (k >= DEPTH && k < N)      chk("sat_sum1", if1.out_data, 32'h7FFF_0000);
      if (k >= N && k < N + DEPTH)  chk("sat_diff1", if1.out_data, 32'h0);
    end

    // Alternating in_valid: the model checks values and the one-cycle latency.
    for (int k = 0; k < 2 * N; k++) begin
      cyc({16'(k < N ? k + 1 : 0), 16'h0}, 1'b1, 1'b0);
      cyc(32'hDEAD_BEEF, 1'b0, 1'b0);
    end

    // Flush mid-frame is ignored, with and without a sample present.
    for (int k = 0; k < N; k++) begin
      if (k == 3) begin
        cyc(32'h0, 1'b0, 1'b1);
        chk("flush_ign_rdy", {31'b0, if0.in_ready}, 32'd1);
        cyc(32'h0004_0000, 1'b1, 1'b1);
      end else begin
        cyc({16'(k + 1), 16'h0}, 1'b1, 1'b0);
      end
    end

    // Reset partway through a frame (cnt=5).
    for (int k = 0; k < 5; k++) cyc({16'(k + 1), 16'h0}, 1'b1, 1'b0);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstm_vld", {30'b0, if0.out_valid, if1.out_valid}, 32'd0);
    chk("rstm_dat", if0.out_data | if1.out_data, 32'd0);
    chk("rstm_flags", {29'b0, if0.out_diff, if0.out_last, if0.in_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      cyc({16'(k + 1), 16'h0}, 1'b1, 1'b0);
      if (k < DEPTH) chk("rstm_noA", {31'b0, if0.out_valid}, 32'd0);
      else           chk("rstm_sum", if0.out_data, {exp_s[k - DEPTH], 16'h0});
    end

    // Random traffic with gaps and random flush requests.
    for (int k = 0; k < 600; k++)
      cyc($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    for (int k = 0; k < 2 * N; k++) cyc(32'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sdf_r2_bfly.md
Name: sdf_r2_bfly

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath.
- Drives one port of the external dual-port delay line (write strobe + data) and consumes that port's output word as the feedback operand.
- For each frame of 2*DEPTH complex samples it emits DEPTH sums, then the DEPTH matching differences recirculated through the delay line.
- Sits directly upstream of the delay line and consumes its output in the same stage.

Parameters:
- WIDTH, 16, bits per real/imag component; sample word is 2*WIDTH (re in [2W-1:W], im in [W-1:0]), signed two's complement.
- DEPTH, 16, delay length = half frame; power of two, 2..128.
- SCALE, 1, 1 = arithmetic shift right by 1 after add/sub; 0 = keep low WIDTH bits (wrap).

Ports:
- clk  in  1  stage clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  2*WIDTH  input complex sample
- in_valid  in  1  sample strobe; accepted only when in_ready=1
- in_ready  out  1  low during FLUSH
- flush  in  1  request to drain the pending differences after the last frame
- dly_wr_data  out  2*WIDTH  word pushed into the delay line
- dly_wr_valid  out  1  delay-line strobe (to the delay line's valid input)
- dly_rd_data  in  2*WIDTH  delay-line output word
- out_data  out  2*WIDTH  butterfly result
- out_valid  out  1  result strobe
- out_diff  out  1  0 = sum word, 1 = difference word
- out_last  out  1  marks the last difference of a frame

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, port reset.
- Delay-line contract: in any cycle with dly_wr_valid=1, dly_rd_data is the word written exactly DEPTH strobes earlier (0 after reset); it is consumed combinationally in that cycle.
- Counter cnt (log2(2*DEPTH) bits) counts accepted samples and wraps 2*DEPTH-1 -> 0. Phase A: cnt < DEPTH. Phase B: cnt >= DEPTH.
- Phase A: dly_wr_data = x; the result is d = dly_rd_data (a stored difference).
- Phase B: a = dly_rd_data, b = x; s = a+b, t = a-b per component at WIDTH+1 bits. Output the scaled s; dly_wr_data = scaled t. Scaling per SCALE.
- dly_wr_valid = (in_valid & in_ready) | flush strobe (combinational).
- Output registered: latency 1 cycle from acceptance. out_valid is asserted for every phase-B sample and for phase-A samples only when primed. out_last = 1 on the output of phase-A sample cnt=DEPTH-1 when primed.
- FSM states:
  - EMPTY: reset state. Moves to RUN when cnt wraps B->A; primed is set on that transition.
  - RUN: steady-state streaming.
  - FLUSH: entered from RUN when flush=1, cnt=0 and in_valid=0; otherwise flush is ignored. In FLUSH, in_ready=0 and the block issues DEPTH internal strobes on consecutive cycles with x=0, outputting the stored differences. After the last strobe: primed cleared, cnt=0, go to EMPTY.
- Reset values: out_data=0, out_valid=0, out_diff=0, out_last=0, in_ready=1, cnt=0, state=EMPTY. The delay line shares the same reset.
- Reset mid-frame aborts immediately; partial frame data is discarded, with no output glitch after release.
- in_valid gaps are allowed anywhere; cnt and strobes stall and no bubbles corrupt the pairing.

Decomposition:
- Package sdf_pkg:
  - state enum typedef (EMPTY/RUN/FLUSH)
  - complex-word pack/unpack helpers
  - add/sub-with-scale function shared with later FFT stages
- Natural sub-module: sdf_cplx_addsub (combinational complex add/sub with scaling, instantiated once).
- FSM/counter stays in the top level.

Test Plan (delay line modelled behaviourally; DEPTH=4, WIDTH=16):
- SCALE=0, re inputs 1..8, im=0, continuous -> outputs re 6,8,10,12 (out_diff=0); next frame 0s -> re -4,-4,-4,-4 (out_diff=1, out_last on the 4th).
- SCALE=1, inputs re=32767 repeated 8 -> sums 32767, no overflow; differences 0.
- Same as first test with in_valid toggling 1010... -> identical values, each output 1 cycle after its accepted input.
- Frame 1..8, then flush=1 at cnt=0 -> in_ready=0 for 4 cycles, outputs -4 x4, out_last on the last, then state EMPTY.
- reset asserted at cnt=5 -> all outputs 0 in the same cycle; restarted frame 1..8 -> sums 6,8,10,12, and no phase-A outputs before the first wrap.
- flush asserted at cnt=3 -> ignored, streaming continues unchanged.
